stack_unwinder: RTL and testbench
=================================

# stack_unwinder

Sequencer that drives the push/pop port of the operand stack to carry out WebAssembly block-exit and branch unwinding. It keeps the top `K` values, where `K` is 0..3. It discards the `D` entries beneath them, where `D` is 0..2^CNT_W-1. It then pushes the kept values back in their original order. It sits between the control unit, which issues unwind commands over a valid/ready handshake, and the operand stack. While it is busy it is the sole master of the stack's `push_num`/`pop_num`/`push_data` inputs.

## Interface
Parameters:
- `WIDTH`, default 32: stack entry width; must equal the stack's entry width.
- `CNT_W`, default 10: width of the drop count.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  unwind command present.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_keep`  in  2  `K`, the number of top entries preserved (0..3).
- `cmd_drop`  in  CNT_W  `D`, the number of entries discarded below the kept ones.
- `stk_push_num`  out  1  push request to the stack.
- `stk_pop_num`  out  4  pop count to the stack (0..15).
- `stk_push_data`  out  WIDTH  data pushed.
- `stk_win_a` / `stk_win_b` / `stk_win_c`  in  WIDTH each  stack top, top-1 and top-2 windows.
- `stk_exceed_pop`  in  1  stack underflow flag, combinational from the current pop count.
- `stk_exceed_push`  in  1  stack overflow flag, combinational.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at command completion.
- `err`  out  1  valid with `done`; high if underflow or overflow was seen during the command.

## Operation
States and transitions:
- **IDLE:** `cmd_ready`=1.
  - On `cmd_valid`, latch `K` and `D`, clear the error flag and go to CAPTURE.
- **CAPTURE:** one cycle.
  - Latch `k0`=`stk_win_a`, `k1`=`stk_win_b`, `k2`=`stk_win_c`.
  - Drive `stk_pop_num`=`K`.
  - Next state is DROP if `D`>0, else RESTORE if `K`>0, else DONE.
- **DROP:** each cycle drives `stk_pop_num`=min(15, rem), where rem is the remaining drop count.
  - Set rem = rem − popped.
  - When rem reaches 0, go to RESTORE if `K`>0, else DONE.
- **RESTORE:** one push per cycle, deepest kept value first: k2, k1, k0 for K=3; k1, k0 for K=2; k0 for K=1.
  - Drive `stk_push_num`=1, `stk_pop_num`=0 and `stk_push_data` from a down-counting index.
  - After the last push, go to DONE.
- **DONE:** one cycle.
  - Drive `done`=1 and drive `err` from the sticky error flag.
  - Return to IDLE.

Error handling:
- Any cycle with `stk_pop_num`≠0 and `stk_exceed_pop`=1 sets the sticky error flag. The stack clamps its pointer to 0 on underflow.
- Any cycle with `stk_push_num`=1 and `stk_exceed_push`=1 also sets the sticky error flag.
- An underflow in CAPTURE or DROP aborts the command: go directly to DONE and skip RESTORE.
- An overflow in RESTORE does not abort; the remaining pushes still occur.

Stack-port defaults and width rules:
- Outside CAPTURE, DROP and RESTORE: `stk_push_num`=0, `stk_pop_num`=0, `stk_push_data`=0.
- Window values are read only in CAPTURE.
- Windows for positions beyond the stack depth may be undriven (Z); they are latched but never pushed, because those positions are ≥ K.
- rem is CNT_W bits and the subtraction never wraps: min(15, rem) ≤ rem.

## Timing
- Reset values: `cmd_ready`=0 during reset and 1 after reset release. `busy`, `done`, `err` and all `stk_*` outputs are 0.
- All stack-port outputs are combinational from registered state only; there is no combinational path from `cmd_*`.
- The handshake completes on a rising edge with `cmd_valid` & `cmd_ready`. CAPTURE is the next cycle.
- Commands presented while `busy` are held off (`cmd_ready`=0). The requester must hold `cmd_*` stable until accepted.
- Latency from acceptance to `done`: 1 (CAPTURE) + ceil(D/15) (DROP) + K (RESTORE) + 1 (DONE) cycles, except on an underflow abort.
- Back-to-back commands: a new command can be accepted in the cycle after DONE, i.e. the IDLE cycle.
- Asserting `rst_n` low mid-command returns the block to IDLE immediately and drives all outputs to reset values. Stack contents are not restored.

## Test plan
- **K=1, D=2:** stack [10,20,30,40], top=40 → pops 1 then 2, pushes 40.
  - Stack ends [10,40]; `done` 4 cycles after acceptance; `err`=0.
- **K=3, D=0:** stack [1,2,3] → pops 3, pushes 1, 2, 3 in that order.
  - Stack unchanged; latency 5 cycles.
- **K=0, D=40:** 50-entry stack → DROP pops 15, 15, 10.
  - Pointer ends at 10; `done` at cycle 5.
- **K=2, D=5:** 4-entry stack → `stk_exceed_pop` in DROP; the block aborts.
  - `done`=1 with `err`=1; no pushes; pointer 0.
- **Busy hold-off and reset:** `cmd_valid` held during a busy command → accepted only in the IDLE cycle after `done`.
  - `rst_n` pulsed low during DROP → `busy`=0 and all `stk_*` outputs 0 in the same cycle.

Source files
------------

// File: rtl/stack_unwinder_if.sv
// Purpose: bundles the unwind command handshake, operand-stack port and status of stack_unwinder.
// Latency: none (wiring only).
// Backpressure: cmd_valid/cmd_ready handshake; the stack side has no backpressure.
//
// Ports/signals:
//   cmd_valid/cmd_ready/cmd_keep/cmd_drop  unwind command from the control unit
//   stk_push_num/stk_pop_num/stk_push_data  requests driven into the operand stack
//   stk_win_a/b/c, stk_exceed_pop/push      stack top windows and under/overflow flags
//   busy/done/err                           sequencer status
// Modports: slave = the unwinder itself, master = control unit plus operand stack.
interface stack_unwinder_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 10
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_keep;
    logic [CNT_W-1:0] cmd_drop;

    logic             stk_push_num;
    logic [3:0]       stk_pop_num;
    logic [WIDTH-1:0] stk_push_data;
    logic [WIDTH-1:0] stk_win_a;
    logic [WIDTH-1:0] stk_win_b;
    logic [WIDTH-1:0] stk_win_c;
    logic             stk_exceed_pop;
    logic             stk_exceed_push;

    logic             busy;
    logic             done;
    logic             err;

    modport slave (
        input  cmd_valid, cmd_keep, cmd_drop,
        output cmd_ready,
        output stk_push_num, stk_pop_num, stk_push_data,
        input  stk_win_a, stk_win_b, stk_win_c, stk_exceed_pop, stk_exceed_push,
        output busy, done, err
    );

    modport master (
        output cmd_valid, cmd_keep, cmd_drop,
        input  cmd_ready,
        input  stk_push_num, stk_pop_num, stk_push_data,
        output stk_win_a, stk_win_b, stk_win_c, stk_exceed_pop, stk_exceed_push,
        input  busy, done, err
    );
endinterface

// File: rtl/stack_unwinder.sv
// Purpose: unwinds the operand stack for block exit/branch: keep top K (0..3), drop D below, re-push kept.
// Latency: accept -> done = 1 + ceil(D/15) + K + 1 cycles; shorter on an underflow abort.
// Backpressure: cmd_ready only in IDLE; commands offered while busy are held off until the IDLE cycle.
//
// Ports: clk, rst_n (async active-low), bus (stack_unwinder_if.slave): command handshake in,
//        stack push/pop/data out, stack windows and exceed flags in, busy/done/err out.
// All outputs come straight from registers; only the error detection looks at the stack flags.
module stack_unwinder #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 10   // must be at least 4 so a 15-entry pop chunk fits in rem
) (
    input  logic              clk,
    input  logic              rst_n,
    stack_unwinder_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        DROP,
        RESTORE,
        DONE
    } state_t;

    state_t           state;
    logic [1:0]       keep_q;
    logic [1:0]       idx_q;
    logic [CNT_W-1:0] rem_q;
    logic             err_flag;
    logic [WIDTH-1:0] kv [3];

    // registered outputs
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             push_q;
    logic [3:0]       pop_q;
    logic [WIDTH-1:0] data_q;

    logic             err_hit;
    logic [CNT_W-1:0] rem_left;
    logic [WIDTH-1:0] win_kept;

    // Largest pop the stack port can express in one cycle.
    function automatic logic [3:0] pop_chunk(input logic [CNT_W-1:0] r);
        if (r > CNT_W'(15)) begin
            return 4'd15;
        end
        return r[3:0];
    endfunction

    // The exceed flags describe the request currently on the port, so they are
    // qualified with the registered request that produced them.
    assign err_hit  = ((pop_q != 4'd0) && bus.stk_exceed_pop) ||
                      (push_q && bus.stk_exceed_push);

    // pop_q never exceeds rem_q in DROP, so this cannot wrap.
    assign rem_left = rem_q - CNT_W'(pop_q);

    // Deepest kept value straight from the windows, used when RESTORE follows
    // CAPTURE directly and kv is not yet loaded.
    always_comb begin
        win_kept = '0;
        case (keep_q)
            2'd1:    win_kept = bus.stk_win_a;
            2'd2:    win_kept = bus.stk_win_b;
            2'd3:    win_kept = bus.stk_win_c;
            default: win_kept = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            keep_q   <= 2'd0;
            idx_q    <= 2'd0;
            rem_q    <= '0;
            err_flag <= 1'b0;
            kv[0]    <= '0;
            kv[1]    <= '0;
            kv[2]    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            push_q   <= 1'b0;
            pop_q    <= 4'd0;
            data_q   <= '0;
        end else begin
            // Stack port and status pulses idle unless a state drives them below.
            push_q <= 1'b0;
            pop_q  <= 4'd0;
            data_q <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.cmd_valid && ready_q) begin
                        keep_q   <= bus.cmd_keep;
                        rem_q    <= bus.cmd_drop;
                        err_flag <= 1'b0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        pop_q    <= {2'b00, bus.cmd_keep};  // CAPTURE pops the kept values
                        state    <= CAPTURE;
                    end else begin
                        ready_q  <= 1'b1;
                    end
                end

                CAPTURE: begin
                    // Windows still show the pre-pop top during this cycle.
                    kv[0]    <= bus.stk_win_a;
                    kv[1]    <= bus.stk_win_b;
                    kv[2]    <= bus.stk_win_c;
                    err_flag <= err_flag | err_hit;
                    if (err_hit) begin
                        err_q  <= 1'b1;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else if (rem_q != '0) begin
                        pop_q  <= pop_chunk(rem_q);
                        state  <= DROP;
                    end else if (keep_q != 2'd0) begin
                        push_q <= 1'b1;
                        data_q <= win_kept;
                        idx_q  <= keep_q - 2'd1;
                        state  <= RESTORE;
                    end else begin
                        err_q  <= err_flag;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end

                DROP: begin
                    err_flag <= err_flag | err_hit;
                    rem_q    <= rem_left;
                    if (err_hit) begin
                        err_q  <= 1'b1;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else if (rem_left != '0) begin
                        pop_q  <= pop_chunk(rem_left);
                    end else if (keep_q != 2'd0) begin
                        push_q <= 1'b1;
                        data_q <= kv[keep_q - 2'd1];
                        idx_q  <= keep_q - 2'd1;
                        state  <= RESTORE;
                    end else begin
                        err_q  <= err_flag;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end

                RESTORE: begin
                    // Overflow is recorded but the remaining pushes still go out.
                    err_flag <= err_flag | err_hit;
                    if (idx_q == 2'd0) begin
                        err_q  <= err_flag | err_hit;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        push_q <= 1'b1;
                        data_q <= kv[idx_q - 2'd1];
                        idx_q  <= idx_q - 2'd1;
                    end
                end

                DONE: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready     = ready_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;
    assign bus.stk_push_num  = push_q;
    assign bus.stk_pop_num   = pop_q;
    assign bus.stk_push_data = data_q;

endmodule

// File: tb/tb_stack_unwinder.sv
// Purpose: directed self-checking bench for stack_unwinder with a behavioural operand stack.
// Latency: n/a.
// Backpressure: the bench holds cmd_* stable until accepted.
module tb_stack_unwinder;

    localparam int WIDTH = 32;
    localparam int CNT_W = 10;
    localparam int DEPTH = 64;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    stack_unwinder_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    stack_unwinder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural operand stack ----------------
    logic [WIDTH-1:0] mem [DEPTH];
    int               ptr;
    logic [WIDTH-1:0] pushed [8];
    int               push_cnt;
    logic [3:0]       pop_log [8];
    int               pop_cnt;

    logic             load_en;
    int               load_n;
    int               load_base;
    int               load_step;

    always_comb begin
        bus.stk_win_a       = (ptr >= 1) ? mem[ptr-1] : 'z;
        bus.stk_win_b       = (ptr >= 2) ? mem[ptr-2] : 'z;
        bus.stk_win_c       = (ptr >= 3) ? mem[ptr-3] : 'z;
        bus.stk_exceed_pop  = (int'(bus.stk_pop_num) > ptr);
        bus.stk_exceed_push = bus.stk_push_num && (ptr >= DEPTH);
    end

    always @(posedge clk) begin
        if (load_en) begin
            ptr      <= load_n;
            push_cnt <= 0;
            pop_cnt  <= 0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= WIDTH'(load_base + i * load_step);
        end else if (bus.stk_pop_num != 4'd0) begin
            ptr <= (int'(bus.stk_pop_num) > ptr) ? 0 : ptr - int'(bus.stk_pop_num);
            if (pop_cnt < 8) pop_log[pop_cnt] <= bus.stk_pop_num;
            pop_cnt <= pop_cnt + 1;
        end else if (bus.stk_push_num) begin
            if (ptr < DEPTH) begin
                mem[ptr] <= bus.stk_push_data;
                ptr      <= ptr + 1;
            end
            if (push_cnt < 8) pushed[push_cnt] <= bus.stk_push_data;
            push_cnt <= push_cnt + 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int n, input int base, input int step);
        @(negedge clk);
        load_n    = n;
        load_base = base;
        load_step = step;
        load_en   = 1'b1;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    // Presents a command, waits for acceptance, then counts cycles from CAPTURE (=1)
    // to the cycle that shows done. lat stays -1 if done never arrives.
    task automatic run_cmd(input logic [1:0] k, input logic [CNT_W-1:0] d,
                           output int lat, output logic e);
        lat = -1;
        e   = 1'bx;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_keep  = k;
        bus.cmd_drop  = d;
        for (int n = 0; n < 20 && !bus.cmd_ready; n++) @(negedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int c = 1; c < 80; c++) begin
            if (bus.done) begin
                lat = c;
                e   = bus.err;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    int   lat;
    logic e;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_keep  = 2'd0;
        bus.cmd_drop  = '0;
        load_en       = 1'b0;
        load_n        = 0;
        load_base     = 0;
        load_step     = 0;

        // reset values
        #2;
        chk("rst_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_done",  32'(bus.done), 32'd0);
        chk("rst_err",   32'(bus.err), 32'd0);
        chk("rst_push",  32'(bus.stk_push_num), 32'd0);
        chk("rst_pop",   32'(bus.stk_pop_num), 32'd0);
        chk("rst_data",  bus.stk_push_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_ready", 32'(bus.cmd_ready), 32'd1);
        chk("idle_busy",  32'(bus.busy), 32'd0);

        // K=1, D=2 on [10,20,30,40]
        load(4, 10, 10);
        run_cmd(2'd1, 10'd2, lat, e);
        chk("t1_lat",   32'(lat), 32'd4);
        chk("t1_err",   32'(e), 32'd0);
        chk("t1_ptr",   32'(ptr), 32'd2);
        chk("t1_mem0",  mem[0], 32'd10);
        chk("t1_mem1",  mem[1], 32'd40);
        chk("t1_npush", 32'(push_cnt), 32'd1);
        chk("t1_pop0",  32'(pop_log[0]), 32'd1);
        chk("t1_pop1",  32'(pop_log[1]), 32'd2);

        // K=3, D=0 on [1,2,3]: pushes 1,2,3
        load(3, 1, 1);
        run_cmd(2'd3, 10'd0, lat, e);
        chk("t2_lat",   32'(lat), 32'd5);
        chk("t2_err",   32'(e), 32'd0);
        chk("t2_ptr",   32'(ptr), 32'd3);
        chk("t2_psh0",  pushed[0], 32'd1);
        chk("t2_psh1",  pushed[1], 32'd2);
        chk("t2_psh2",  pushed[2], 32'd3);
        chk("t2_mem2",  mem[2], 32'd3);

        // K=0, D=40 on 50 entries: pops 15,15,10
        load(50, 100, 1);
        run_cmd(2'd0, 10'd40, lat, e);
        chk("t3_lat",   32'(lat), 32'd5);
        chk("t3_err",   32'(e), 32'd0);
        chk("t3_ptr",   32'(ptr), 32'd10);
        chk("t3_npop",  32'(pop_cnt), 32'd3);
        chk("t3_pop0",  32'(pop_log[0]), 32'd15);
        chk("t3_pop1",  32'(pop_log[1]), 32'd15);
        chk("t3_pop2",  32'(pop_log[2]), 32'd10);
        chk("t3_npush", 32'(push_cnt), 32'd0);

        // K=2, D=5 on 4 entries: underflow in DROP aborts
        load(4, 1, 1);
        run_cmd(2'd2, 10'd5, lat, e);
        chk("t4_lat",   32'(lat), 32'd3);
        chk("t4_err",   32'(e), 32'd1);
        chk("t4_npush", 32'(push_cnt), 32'd0);
        chk("t4_ptr",   32'(ptr), 32'd0);

        // K=1, D=0 on a 1-entry stack: deeper windows are Z but never pushed
        load(1, 7, 1);
        run_cmd(2'd1, 10'd0, lat, e);
        chk("t5_lat",   32'(lat), 32'd3);
        chk("t5_err",   32'(e), 32'd0);
        chk("t5_psh0",  pushed[0], 32'd7);
        chk("t5_ptr",   32'(ptr), 32'd1);

        // busy hold-off: second command held during first, accepted in the IDLE cycle
        load(4, 10, 10);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_keep  = 2'd1;
        bus.cmd_drop  = 10'd2;
        for (int n = 0; n < 20 && !bus.cmd_ready; n++) @(negedge clk);
        @(negedge clk);
        bus.cmd_keep  = 2'd0;
        bus.cmd_drop  = 10'd1;
        lat = -1;
        for (int c = 1; c < 40; c++) begin
            chk("t6_holdoff_ready", 32'(bus.cmd_ready), 32'd0);
            if (bus.done) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        chk("t6_a_lat", 32'(lat), 32'd4);
        @(negedge clk);
        chk("t6_idle_ready", 32'(bus.cmd_ready), 32'd1);
        chk("t6_idle_busy",  32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("t6_b_busy", 32'(bus.busy), 32'd1);
        bus.cmd_valid = 1'b0;
        lat = -1;
        for (int c = 1; c < 40; c++) begin
            if (bus.done) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        chk("t6_b_lat", 32'(lat), 32'd3);
        chk("t6_b_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        chk("t6_ptr", 32'(ptr), 32'd1);

        // reset pulsed during DROP
        load(50, 100, 1);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_keep  = 2'd0;
        bus.cmd_drop  = 10'd40;
        for (int n = 0; n < 20 && !bus.cmd_ready; n++) @(negedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("t7_drop_pop", 32'(bus.stk_pop_num), 32'd15);
        rst_n = 1'b0;
        #1;
        chk("t7_busy",  32'(bus.busy), 32'd0);
        chk("t7_pop",   32'(bus.stk_pop_num), 32'd0);
        chk("t7_push",  32'(bus.stk_push_num), 32'd0);
        chk("t7_data",  bus.stk_push_data, 32'd0);
        chk("t7_done",  32'(bus.done), 32'd0);
        chk("t7_ready", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t7_post_ready", 32'(bus.cmd_ready), 32'd1);
        chk("t7_post_busy",  32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
